// File: rtl/qspi_read_seq.sv
// qspi_read_seq: Quad Output Fast Read (0x6B) sequencer for the flash side of the bridge.
// Runs the command, address, dummy and quad data phases. Bytes come out on a
// valid/ready stream, and SCK is held low while a completed byte waits for the consumer.
// Optional feature: define QSPI_ABORT_EN to add the abort input and aborted output.
module qspi_read_seq #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned CS_HOLD      = 4
) (
    input  logic        mclk,
    input  logic        RESET,
    input  logic        req,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        cs_n,
    output logic        sck,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    input  logic [3:0]  io_in
`ifdef QSPI_ABORT_EN
    ,
    input  logic        abort,
    output logic        aborted
`endif
);

    localparam logic [7:0] CMD_QOFR = 8'h6B;

    typedef enum logic [2:0] {IDLE, CSSETUP, CMD, ADDR, DUMMY, DATA, CSHOLD} state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic [7:0]  bit_cnt;     // SCK cycles completed in the current phase
    logic [31:0] shreg;       // command + address, shifted out MSB first
    logic [15:0] byte_cnt;    // bytes still to capture
    logic [3:0]  hi_nib;
    logic [3:0]  lo_nib;      // low nibble parked while the output register is full
    logic        nib_sel;     // 0: next sample is the high nibble
    logic        stall;       // completed byte waiting for rd_data to free up
    logic        last_byte;
    logic [15:0] hold_cnt;
    logic        tick;
    logic        rise;
    logic        fall;
`ifdef QSPI_ABORT_EN
    logic        abort_pend;  // abort seen while sck was high, act at the next low point
    logic        abort_flag;
`endif

    // Divider tick; frozen while a completed byte is parked
    assign tick = !cs_n && !stall && ({16'd0, div_cnt} == CLK_DIV - 1);
    assign rise = tick && !sck;
    assign fall = tick && sck;

    // Sequencer FSM with registered pin and stream outputs
    always_ff @(posedge mclk) begin
        if (RESET) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            io_out    <= 4'h0;
            io_oe     <= 4'h0;
            div_cnt   <= 16'd0;
            bit_cnt   <= 8'd0;
            shreg     <= 32'd0;
            byte_cnt  <= 16'd0;
            hi_nib    <= 4'h0;
            lo_nib    <= 4'h0;
            nib_sel   <= 1'b0;
            stall     <= 1'b0;
            last_byte <= 1'b0;
            hold_cnt  <= 16'd0;
`ifdef QSPI_ABORT_EN
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            abort_flag <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef QSPI_ABORT_EN
            aborted <= 1'b0;
`endif
            if (rd_valid && rd_ready) rd_valid <= 1'b0;
            if (!cs_n && !stall) div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (req) begin
                        if (len != 16'd0) begin
                            state     <= CSSETUP;
                            busy      <= 1'b1;
                            cs_n      <= 1'b0;
                            sck       <= 1'b0;
                            div_cnt   <= 16'd0;
                            shreg     <= {CMD_QOFR, addr};
                            byte_cnt  <= len;
                            io_out    <= {3'b000, CMD_QOFR[7]};
                            io_oe     <= 4'b0001;
                            bit_cnt   <= 8'd0;
                            nib_sel   <= 1'b0;
                            stall     <= 1'b0;
                            last_byte <= 1'b0;
`ifdef QSPI_ABORT_EN
                            abort_pend <= 1'b0;
                            abort_flag <= 1'b0;
`endif
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                CSSETUP: begin
                    if (rise) begin
                        sck   <= 1'b1;
                        state <= CMD;
                    end
                end
                CMD, ADDR: begin
                    if (rise) begin
                        sck <= 1'b1;
                    end else if (fall) begin
                        sck     <= 1'b0;
                        shreg   <= {shreg[30:0], 1'b0};
                        io_out  <= {3'b000, shreg[30]};
                        bit_cnt <= bit_cnt + 8'd1;
                        if (state == CMD && bit_cnt == 8'd7) begin
                            state   <= ADDR;
                            bit_cnt <= 8'd0;
                        end else if (state == ADDR && bit_cnt == 8'd23) begin
                            io_out  <= 4'h0;
                            io_oe   <= 4'h0;
                            bit_cnt <= 8'd0;
                            nib_sel <= 1'b0;
                            state   <= (DUMMY_CYCLES == 0) ? DATA : DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (rise) begin
                        sck <= 1'b1;
                    end else if (fall) begin
                        sck     <= 1'b0;
                        bit_cnt <= bit_cnt + 8'd1;
                        if ({24'd0, bit_cnt} == DUMMY_CYCLES - 1) begin
                            bit_cnt <= 8'd0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (stall) begin
                        if (!rd_valid || rd_ready) begin
                            rd_data  <= {hi_nib, lo_nib};
                            rd_valid <= 1'b1;
                            stall    <= 1'b0;
                        end
                    end else if (rise) begin
                        // After the last byte one more low half-period passes before cs_n rises
                        if (last_byte) begin
                            state    <= CSHOLD;
                            cs_n     <= 1'b1;
                            hold_cnt <= 16'd0;
                        end else begin
                            sck <= 1'b1;
                        end
                    end else if (fall) begin
                        sck <= 1'b0;
                        if (!nib_sel) begin
                            hi_nib  <= io_in;
                            nib_sel <= 1'b1;
                        end else begin
                            nib_sel  <= 1'b0;
                            byte_cnt <= byte_cnt - 16'd1;
                            if (byte_cnt == 16'd1) last_byte <= 1'b1;
                            if (!rd_valid || rd_ready) begin
                                rd_data  <= {hi_nib, io_in};
                                rd_valid <= 1'b1;
                            end else begin
                                lo_nib <= io_in;
                                stall  <= 1'b1;
                            end
                        end
                    end
                end
                CSHOLD: begin
                    if ({16'd0, hold_cnt} + 32'd2 >= CS_HOLD) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef QSPI_ABORT_EN
                        aborted <= abort_flag;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef QSPI_ABORT_EN
            // Abort overrides the phase logic once sck is low; partial bytes are dropped
            if ((abort || abort_pend) && state != IDLE && state != CSHOLD) begin
                if (!sck) begin
                    state      <= CSHOLD;
                    cs_n       <= 1'b1;
                    sck        <= 1'b0;
                    io_out     <= 4'h0;
                    io_oe      <= 4'h0;
                    hold_cnt   <= 16'd0;
                    stall      <= 1'b0;
                    abort_pend <= 1'b0;
                    abort_flag <= 1'b1;
                end else begin
                    abort_pend <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
